// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit: 32 shift-add or restoring shift-subtract steps.
// Define MULT_DIV_SIGNED_EN to make ops 0 (mult) and 2 (div) signed; otherwise they act as multu/divu.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [63:0] p;      // {partial hi / remainder, multiplier / dividend-quotient}
  logic [31:0] d;      // multiplicand or divisor magnitude
  logic        is_div, dz_q;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sum, sh, diff;
  logic        ge;
  logic [63:0] prod_res;
  logic [31:0] q_res, r_res;

`ifdef MULT_DIV_SIGNED_EN
  logic is_sgn, a_neg, b_neg, neg_lo, neg_hi;
  assign is_sgn   = ~op[0];
  assign a_neg    = is_sgn & A[31];
  assign b_neg    = is_sgn & B[31];
  assign a_mag    = a_neg ? -A : A;
  assign b_mag    = b_neg ? -B : B;
  // product/quotient sign is the xor of operand signs; remainder follows the dividend
  assign prod_res = neg_lo ? -p : p;
  assign q_res    = neg_lo ? -p[31:0] : p[31:0];
  assign r_res    = neg_hi ? -p[63:32] : p[63:32];
`else
  assign a_mag    = A;
  assign b_mag    = B;
  assign prod_res = p;
  assign q_res    = p[31:0];
  assign r_res    = p[63:32];
`endif

  assign sum  = {1'b0, p[63:32]} + (p[0] ? {1'b0, d} : 33'd0);
  assign sh   = {p[63:32], p[31]};
  assign diff = sh - {1'b0, d};
  assign ge   = (sh >= {1'b0, d});

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == 6'd32) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    div_by_zero = done & dz_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      p      <= '0;
      d      <= '0;
      is_div <= 1'b0;
      dz_q   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
`ifdef MULT_DIV_SIGNED_EN
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt    <= '0;
          is_div <= op[1];
          dz_q   <= op[1] & (B == 32'd0);
          p      <= op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
          d      <= op[1] ? b_mag : a_mag;
`ifdef MULT_DIV_SIGNED_EN
          neg_lo <= a_neg ^ b_neg;
          neg_hi <= op[1] ? a_neg : (a_neg ^ b_neg);
`endif
        end
        CALC: begin
          if (cnt != 6'd32) begin
            cnt <= cnt + 6'd1;
            if (is_div) p <= {(ge ? diff[31:0] : sh[31:0]), p[30:0], ge};
            else        p <= {sum, p[31:1]};
          end else if (is_div) begin
            // B=0 yields all-ones quotient and |A| remainder, so only LO needs forcing
            LO <= dz_q ? 32'hFFFF_FFFF : q_res;
            HI <= r_res;
          end else begin
            {HI, LO} <= prod_res;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
